// File: rtl/sm_clk_stepper.sv
// -----------------------------------------------------------------------------
// sm_clk_stepper
//
// Divided CPU clock generator with debug stepping. The divided clock is a
// registered copy of one bit of a free-running counter, selected by `devide`
// relative to SHIFT and clamped to the counter MSB. On top of plain division
// the block offers a clean halt (the clock is always parked low) and a
// single-step burst of N full clock periods started by a rising edge on
// stepReq.
//
// Ports:
//   clkIn      in   system clock
//   rst_n      in   asynchronous active-low reset
//   devide     in   divide select, k = min(SHIFT + devide, WIDTH-1)
//   enable     in   global enable; 0 freezes every register, clkOut holds
//   mode       in   00 RUN, 01 HALT, 10 STEP, 11 HALT
//   stepReq    in   level; its rising edge starts a burst while halted
//   stepCount  in   periods per burst, 0 is treated as 1
//   clkOut     out  divided clock, period 2^(k+1) clkIn cycles, 50% duty
//   clkTick    out  one-cycle pulse coincident with clkOut rising
//   halted     out  high while parked in the HALTED state
//   stepsLeft  out  clock periods remaining in the current burst
// -----------------------------------------------------------------------------
module sm_clk_stepper #(
  parameter int WIDTH  = 32,
  parameter int SHIFT  = 16,
  parameter int DIV_W  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clkIn,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  devide,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              stepReq,
  input  logic [STEP_W-1:0] stepCount,
  output logic              clkOut,
  output logic              clkTick,
  output logic              halted,
  output logic [STEP_W-1:0] stepsLeft
);

  localparam int K_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DRAIN  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;
  localparam logic [1:0] ST_STEP   = 2'b11;

  logic [1:0]        state_q,    state_d;
  logic [WIDTH-1:0]  cntr_q,     cntr_d;
  logic              clk_out_q,  clk_out_d;
  logic              tick_q,     tick_d;
  logic [STEP_W-1:0] steps_q,    steps_d;
  logic              step_req_q, step_req_d;

  int                k_sum;
  logic [K_W-1:0]    k_idx;
  logic              bit_k;
  logic              fall;
  logic              step_rise;

  // Selected counter bit; the index saturates at the MSB instead of wrapping.
  always_comb begin
    k_sum = SHIFT + int'(devide);
    if (k_sum > WIDTH - 1) begin
      k_sum = WIDTH - 1;
    end
    k_idx = K_W'(k_sum);
  end

  assign bit_k = cntr_q[k_idx];

  // clkOut mirrors bit_k one cycle late, so a registered high with a low
  // counter bit means clkOut falls on the coming edge.
  assign fall      = clk_out_q & ~bit_k;
  assign step_rise = stepReq & ~step_req_q;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    cntr_d     = cntr_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    steps_d    = steps_q;
    step_req_d = step_req_q;

    if (enable) begin
      step_req_d = stepReq;

      case (state_q)
        ST_RUN: begin
          if (mode != MODE_RUN) begin
            state_d = ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (mode == MODE_RUN) begin
            state_d = ST_RUN;
          end else if (!clk_out_q || fall) begin
            state_d = ST_HALTED;
          end
        end

        ST_HALTED: begin
          if (mode == MODE_RUN) begin
            state_d = ST_RUN;
          end else if (mode == MODE_STEP && step_rise) begin
            state_d = ST_STEP;
            steps_d = (stepCount == '0) ? STEP_W'(1) : stepCount;
          end
        end

        default: begin // ST_STEP
          if (mode == MODE_RUN) begin
            state_d = ST_RUN;
            steps_d = '0;
          end else if (mode != MODE_STEP) begin
            // Abandon the burst but still finish the current high phase.
            state_d = ST_DRAIN;
            steps_d = '0;
          end else if (fall) begin
            if (steps_q == STEP_W'(1)) begin
              state_d = ST_HALTED;
              steps_d = '0;
            end else begin
              steps_d = steps_q - STEP_W'(1);
            end
          end
        end
      endcase

      if (state_q != ST_HALTED) begin
        cntr_d = cntr_q + WIDTH'(1);
      end

      // The halted counter can sit anywhere in a period (an early halt or a
      // devide change); restarting it from zero makes the first burst period
      // full length instead of a runt.
      if (state_q == ST_HALTED && state_d == ST_STEP) begin
        cntr_d = '0;
      end

      // Keep the clock parked low while halted and on the way in or out.
      if (state_q == ST_HALTED || state_d == ST_HALTED) begin
        clk_out_d = 1'b0;
      end else begin
        clk_out_d = bit_k;
      end

      tick_d = clk_out_d & ~clk_out_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cntr_q     <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      steps_q    <= '0;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cntr_q     <= cntr_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      steps_q    <= steps_d;
      step_req_q <= step_req_d;
    end
  end

  assign clkOut    = clk_out_q;
  assign clkTick   = tick_q;
  assign halted    = (state_q == ST_HALTED);
  assign stepsLeft = steps_q;

endmodule

// File: tb/tb_sm_clk_stepper.sv
// -----------------------------------------------------------------------------
// tb_sm_clk_stepper
//
// Directed bench for sm_clk_stepper. The main instance uses WIDTH=16, SHIFT=2;
// a second instance with WIDTH=8, SHIFT=2 and devide tied to 15 covers the
// index clamp. Inputs change and outputs are sampled 1 ns after each rising
// edge of clkIn.
// -----------------------------------------------------------------------------
module tb_sm_clk_stepper;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic [3:0] devide;
  logic       enable;
  logic [1:0] mode;
  logic       step_req;
  logic [7:0] step_count;
  logic       clk_out;
  logic       clk_tick;
  logic       halted;
  logic [7:0] steps_left;

  logic       c_clk_out;
  logic       c_tick;
  logic       c_halted;
  logic [7:0] c_steps;

  int checks   = 0;
  int failures = 0;
  int seq[$];

  always #5 clk_in = ~clk_in;

  sm_clk_stepper #(.WIDTH(16), .SHIFT(2), .DIV_W(4), .STEP_W(8)) u_dut (
    .clkIn     (clk_in),
    .rst_n     (rst_n),
    .devide    (devide),
    .enable    (enable),
    .mode      (mode),
    .stepReq   (step_req),
    .stepCount (step_count),
    .clkOut    (clk_out),
    .clkTick   (clk_tick),
    .halted    (halted),
    .stepsLeft (steps_left)
  );

  sm_clk_stepper #(.WIDTH(8), .SHIFT(2), .DIV_W(4), .STEP_W(8)) u_clamp (
    .clkIn     (clk_in),
    .rst_n     (rst_n),
    .devide    (4'hF),
    .enable    (1'b1),
    .mode      (2'b00),
    .stepReq   (1'b0),
    .stepCount (8'd0),
    .clkOut    (c_clk_out),
    .clkTick   (c_tick),
    .halted    (c_halted),
    .stepsLeft (c_steps)
  );

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Edges until the next tick; -1 when the budget runs out (a failed check).
  task automatic wait_tick(input bit use_clamp, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      cyc();
      if (use_clamp ? c_tick : clk_tick) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      failures++;
      $display("FAIL wait_tick: no tick within %0d cycles", budget);
    end
  endtask

  // Called on a tick sample: counts consecutive high samples of clkOut.
  task automatic measure_high(input bit use_clamp, output int hi,
                              output bit tick_after, output bit x_seen);
    hi         = 1;
    tick_after = 1'b0;
    x_seen     = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (i == 0) tick_after = use_clamp ? c_tick : clk_tick;
      if ($isunknown(use_clamp ? c_clk_out : clk_out)) x_seen = 1'b1;
      if (use_clamp ? c_clk_out : clk_out) hi++;
      else break;
    end
  endtask

  task automatic run_burst(input int ncyc, input int pause_at, input int pause_len,
                           input int reedge_at, output int ticks, output int pause_bad);
    logic [7:0] last, hold_s;
    logic       hold_c;
    seq.delete();
    last      = steps_left;
    ticks     = 0;
    pause_bad = 0;
    for (int c = 0; c < ncyc; c++) begin
      cyc();
      if (clk_tick) ticks++;
      if (steps_left != last) begin
        seq.push_back(int'(steps_left));
        last = steps_left;
      end
      if (c == reedge_at)     step_req = 1'b0;
      if (c == reedge_at + 2) step_req = 1'b1;
      if (c == pause_at) begin
        enable = 1'b0;
        hold_s = steps_left;
        hold_c = clk_out;
        for (int p = 0; p < pause_len; p++) begin
          cyc();
          if (steps_left !== hold_s || clk_out !== hold_c || clk_tick !== 1'b0) pause_bad++;
        end
        enable = 1'b1;
      end
    end
  endtask

  // True when the recorded stepsLeft history is n, n-1, ..., 0.
  function automatic bit seq_is_countdown(input int n);
    if (seq.size() != n + 1) return 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (seq[i] != n - i) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic go_halted();
    mode = 2'b01;
    for (int i = 0; i < 200 && !halted; i++) cyc();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL go_halted: halted=%b expected 1", halted);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) cyc();
    checks += 4;
    if (clk_out !== 1'b0)     begin failures++; $display("FAIL reset_clkOut: got %b expected 0", clk_out); end
    if (clk_tick !== 1'b0)    begin failures++; $display("FAIL reset_clkTick: got %b expected 0", clk_tick); end
    if (halted !== 1'b0)      begin failures++; $display("FAIL reset_halted: got %b expected 0", halted); end
    if (steps_left !== 8'd0)  begin failures++; $display("FAIL reset_stepsLeft: got %0d expected 0", steps_left); end
    rst_n = 1'b1;
    // Counter from 0: bit2 sets after 4 edges, clkOut follows one edge later.
    wait_tick(1'b0, 50, n);
    checks++;
    if (n != 5) begin failures++; $display("FAIL reset_first_tick: got %0d cycles expected 5", n); end
  endtask

  task automatic test_run_period();
    int  n, hi;
    bit  t1, xs;
    wait_tick(1'b0, 50, n);
    checks++;
    if (n != 8) begin failures++; $display("FAIL run_period_div0: got %0d expected 8", n); end
    measure_high(1'b0, hi, t1, xs);
    checks += 2;
    if (hi != 4)     begin failures++; $display("FAIL run_high_div0: got %0d expected 4", hi); end
    if (t1 !== 1'b0) begin failures++; $display("FAIL tick_width: tick still %b one cycle later, expected 0", t1); end
    devide = 4'd3;
    wait_tick(1'b0, 200, n);
    wait_tick(1'b0, 200, n);
    checks++;
    if (n != 64) begin failures++; $display("FAIL run_period_div3: got %0d expected 64", n); end
    measure_high(1'b0, hi, t1, xs);
    checks++;
    if (hi != 32) begin failures++; $display("FAIL run_high_div3: got %0d expected 32", hi); end
    devide = 4'd0;
    wait_tick(1'b0, 200, n);
  endtask

  task automatic test_clean_halt();
    int n, hi, bad;
    bit t1, xs;
    wait_tick(1'b0, 50, n);
    mode = 2'b01;
    measure_high(1'b0, hi, t1, xs);
    checks += 2;
    if (hi != 4)       begin failures++; $display("FAIL halt_high_len: got %0d expected 4", hi); end
    if (halted !== 1'b1) begin failures++; $display("FAIL halt_entry: halted=%b expected 1", halted); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (clk_out !== 1'b0 || clk_tick !== 1'b0 || halted !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL halt_hold: %0d bad cycles expected 0", bad); end
    // Counter frozen at 9: resume costs one cycle, then 9->12, then clkOut.
    mode = 2'b00;
    wait_tick(1'b0, 50, n);
    checks++;
    if (n != 5) begin failures++; $display("FAIL halt_resume_tick: got %0d expected 5", n); end
  endtask

  task automatic test_step_burst();
    int ticks, pb;
    go_halted();
    step_req   = 1'b0;
    cyc();
    mode       = 2'b10;
    step_count = 8'd3;
    step_req   = 1'b1;
    run_burst(60, -1, 0, -10, ticks, pb);
    step_req = 1'b0;
    checks += 4;
    if (ticks != 3)             begin failures++; $display("FAIL step3_ticks: got %0d expected 3", ticks); end
    if (!seq_is_countdown(3))   begin failures++; $display("FAIL step3_stepsLeft: got %0d changes expected 3,2,1,0", seq.size()); end
    if (halted !== 1'b1)        begin failures++; $display("FAIL step3_halted: got %b expected 1", halted); end
    if (clk_out !== 1'b0)       begin failures++; $display("FAIL step3_clkOut: got %b expected 0", clk_out); end
    cyc();
    step_count = 8'd0;
    step_req   = 1'b1;
    run_burst(40, -1, 0, -10, ticks, pb);
    step_req = 1'b0;
    checks += 3;
    if (ticks != 1)           begin failures++; $display("FAIL step0_ticks: got %0d expected 1", ticks); end
    if (!seq_is_countdown(1)) begin failures++; $display("FAIL step0_stepsLeft: got %0d changes expected 1,0", seq.size()); end
    if (halted !== 1'b1)      begin failures++; $display("FAIL step0_halted: got %b expected 1", halted); end
  endtask

  task automatic test_ignored_request();
    int ticks, pb;
    cyc();
    step_count = 8'd3;
    step_req   = 1'b1;
    run_burst(70, -1, 0, 10, ticks, pb);
    checks += 2;
    if (ticks != 3)      begin failures++; $display("FAIL ignore_ticks: got %0d expected 3", ticks); end
    if (halted !== 1'b1) begin failures++; $display("FAIL ignore_halted: got %b expected 1", halted); end
  endtask

  task automatic test_enable_pause();
    int ticks, pb;
    step_req = 1'b0;
    cyc();
    step_req = 1'b1;
    run_burst(80, 15, 20, -10, ticks, pb);
    step_req = 1'b0;
    checks += 4;
    if (pb != 0)              begin failures++; $display("FAIL pause_hold: %0d changed cycles expected 0", pb); end
    if (ticks != 3)           begin failures++; $display("FAIL pause_ticks: got %0d expected 3", ticks); end
    if (!seq_is_countdown(3)) begin failures++; $display("FAIL pause_stepsLeft: got %0d changes expected 3,2,1,0", seq.size()); end
    if (halted !== 1'b1)      begin failures++; $display("FAIL pause_halted: got %b expected 1", halted); end
  endtask

  task automatic test_async_reset();
    int n;
    cyc();
    step_count = 8'd3;
    step_req   = 1'b1;
    repeat (14) cyc();
    // Second burst period rises on edge 14 with one fall already counted.
    checks++;
    if (clk_tick !== 1'b1 || clk_out !== 1'b1 || steps_left !== 8'd2) begin
      failures++;
      $display("FAIL pre_reset: tick=%b clkOut=%b stepsLeft=%0d expected 1 1 2",
               clk_tick, clk_out, steps_left);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (clk_out !== 1'b0)    begin failures++; $display("FAIL areset_clkOut: got %b expected 0", clk_out); end
    if (clk_tick !== 1'b0)   begin failures++; $display("FAIL areset_clkTick: got %b expected 0", clk_tick); end
    if (halted !== 1'b0)     begin failures++; $display("FAIL areset_halted: got %b expected 0", halted); end
    if (steps_left !== 8'd0) begin failures++; $display("FAIL areset_stepsLeft: got %0d expected 0", steps_left); end
    mode     = 2'b00;
    step_req = 1'b0;
    #1;
    rst_n = 1'b1;
    wait_tick(1'b0, 50, n);
    checks += 2;
    if (n != 5)          begin failures++; $display("FAIL areset_resume: got %0d expected 5", n); end
    if (halted !== 1'b0) begin failures++; $display("FAIL areset_state: halted=%b expected 0", halted); end
  endtask

  task automatic test_clamp();
    int n, hi;
    bit t1, xs;
    wait_tick(1'b1, 600, n);
    wait_tick(1'b1, 600, n);
    checks++;
    if (n != 256) begin failures++; $display("FAIL clamp_period: got %0d expected 256", n); end
    measure_high(1'b1, hi, t1, xs);
    checks += 2;
    if (hi != 128)  begin failures++; $display("FAIL clamp_high: got %0d expected 128", hi); end
    if (xs !== 1'b0) begin failures++; $display("FAIL clamp_x: unknown seen=%b expected 0", xs); end
  endtask

  initial begin
    rst_n      = 1'b0;
    devide     = 4'd0;
    enable     = 1'b1;
    mode       = 2'b00;
    step_req   = 1'b0;
    step_count = 8'd0;
    test_reset();
    test_run_period();
    test_clean_halt();
    test_step_burst();
    test_ignored_request();
    test_enable_pause();
    test_async_reset();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
